onehot_index_serializer: RTL and testbench

ONEHOT_INDEX_SERIALIZER -- requirements
Module: onehot_index_serializer

---
 rtl/onehot_index_serializer_pkg.sv | 12 +
 rtl/onehot_index_serializer_onehot_first_n.sv | 14 +
 rtl/onehot_index_serializer.sv | 86 ++++++++
 tb/tb_onehot_index_serializer.sv | 134 +++++++++++++
 4 files changed

// File: rtl/onehot_index_serializer_pkg.sv
// Shared widths and FSM state type for the one-hot index serializer.
package onehot_index_serializer_pkg;

    localparam int N  = 32;
    localparam int IW = $clog2(N);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

endpackage

// File: rtl/onehot_index_serializer_onehot_first_n.sv
// Isolates the lowest-numbered set bit of a vector as a one-hot word.
module onehot_first_n
    import onehot_index_serializer_pkg::*;
#(
    parameter int W = N
) (
    input  logic [W-1:0] vec,
    output logic [W-1:0] onehot
);

    // Two's-complement trick: x & -x keeps only the lowest set bit.
    assign onehot = vec & (~vec + W'(1));

endmodule

// File: rtl/onehot_index_serializer.sv
// Latches a request vector and emits the index of each set bit, lowest first,
// over a valid/ready output; pulses done once the vector is drained.
module onehot_index_serializer #(
    parameter int N  = onehot_index_serializer_pkg::N,
    parameter int IW = onehot_index_serializer_pkg::IW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_vec,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [IW-1:0] out_idx,
    output logic          out_last,
    output logic          done
);

    import onehot_index_serializer_pkg::*;

    state_t        state_q, state_d;
    logic [N-1:0]  pending_q, pending_d;
    logic          done_q, done_d;
    logic [N-1:0]  first_oh;
    logic [IW-1:0] idx;
    logic          last;

    onehot_first_n #(.W(N)) u_first (
        .vec    (pending_q),
        .onehot (first_oh)
    );

    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (first_oh[i]) idx |= IW'(i);
        end
    end

    // Exactly one bit set when the isolated lowest bit is the whole vector.
    assign last = (pending_q != '0) && (pending_q == first_oh);

    assign in_ready  = !rst && (state_q == IDLE);
    assign out_valid = !rst && (state_q == DRAIN);
    assign out_idx   = out_valid ? idx : '0;
    assign out_last  = out_valid && last;
    assign done      = !rst && done_q;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    pending_d = in_vec;
                    if (in_vec != '0) state_d = DRAIN;
                    else              done_d  = 1'b1;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    pending_d = pending_q & ~first_oh;
                    if (last) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_onehot_index_serializer.sv
// Randomized and directed bench against a queue-based model of the serializer.
module tb_onehot_index_serializer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_vec = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  out_idx;
    logic        out_last;
    logic        done;

    int n_chk  = 0;
    int n_pass = 0;

    // Model: a queue of indices still to emit, plus idle flag and done flag.
    int m_q[$];
    bit m_idle = 1'b1;
    bit m_done = 1'b0;

    always #5 clk = ~clk;

    onehot_index_serializer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .done      (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    // One cycle: check outputs at negedge, drive new inputs, advance the model.
    task automatic step(input bit r, input bit iv, input logic [31:0] v, input bit ordy);
        @(negedge clk);
        chk("in_ready",  32'(in_ready),  32'(m_idle && !rst));
        chk("out_valid", 32'(out_valid), 32'(!m_idle && !rst));
        chk("done",      32'(done),      32'(m_done && !rst));
        if (rst) begin
            chk("rst_idx",  32'(out_idx),  32'd0);
            chk("rst_last", 32'(out_last), 32'd0);
        end else if (!m_idle) begin
            chk("out_idx",  32'(out_idx),  32'(m_q[0]));
            chk("out_last", 32'(out_last), 32'(m_q.size() == 1));
        end
        rst = r; in_valid = iv; in_vec = v; out_ready = ordy;
        if (r) begin
            m_q.delete(); m_idle = 1'b1; m_done = 1'b0;
        end else if (m_idle) begin
            m_done = 1'b0;
            if (iv) begin
                m_q.delete();
                for (int b = 0; b < 32; b++) if (v[b]) m_q.push_back(b);
                if (m_q.size() == 0) m_done = 1'b1;
                else                 m_idle = 1'b0;
            end
        end else begin
            m_done = 1'b0;
            if (ordy) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) begin
                    m_idle = 1'b1; m_done = 1'b1;
                end
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
    endtask

    initial begin
        logic [31:0] v;
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        idle_cycles(1);

        // Sparse vector with top bit.
        step(1'b0, 1'b1, 32'h8000_0005, 1'b1);
        idle_cycles(5);

        // Zero vector: done only, no output.
        step(1'b0, 1'b1, 32'h0, 1'b1);
        idle_cycles(3);

        // Backpressure holds output stable.
        step(1'b0, 1'b1, 32'h0000_0018, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        idle_cycles(4);

        // Full vector with in_vec noise during drain.
        step(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1);
        for (int i = 0; i < 33; i++) step(1'b0, 1'b1, $urandom, 1'b1);
        idle_cycles(2);

        // Reset mid-drain discards the rest, then a fresh vector drains.
        step(1'b0, 1'b1, 32'h0000_00F0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 32'h0000_0102, 1'b1);
        idle_cycles(4);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 4))
                0:       v = 32'h0;
                1:       v = 32'h1 << $urandom_range(0, 31);
                2:       v = $urandom;
                default: v = $urandom & $urandom & $urandom;
            endcase
            step($urandom_range(0, 199) == 0, $urandom_range(0, 2) != 0, v,
                 $urandom_range(0, 3) != 0);
        end
        idle_cycles(40);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
